disp_scan: RTL
==============

DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 Parameter DIV, default 50000, SHALL set the number of clk cycles each digit is lit per scan slot (legal range 2..2^20).
REQ-002 Parameter BLANK_CYC, default 2, SHALL set the number of all-digits-off cycles inserted before each slot (legal range 1..255).
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-low, with ports named clk and rst_n.
REQ-004 Ports SHALL be, in order:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  display enable.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept.
- wr_addr  in  2  target digit 0..3.
- wr_data  in  8  segment pattern; bit=1 means lit, bit7=dp.
- seg  out  8  segment drive, active-low.
- an  out  4  digit anodes, active-low.
- digit_sel  out  2  index of the digit currently scanned.

Function
REQ-005 A write SHALL be accepted on any rising clk edge where wr_valid=1 and wr_ready=1, storing wr_data into shadow[wr_addr].
REQ-006 wr_ready SHALL be 1 in every cycle except the commit cycle (REQ-010) and while rst_n=0.
REQ-007 While wr_valid=1 and wr_ready=0, the requester SHALL hold wr_addr and wr_data stable; acceptance SHALL occur on the next cycle.
REQ-008 The FSM SHALL have states IDLE, BLANK and SHOW, with these transitions:
- IDLE->BLANK when en=1.
- BLANK->SHOW after BLANK_CYC cycles.
- SHOW->BLANK after DIV cycles, with digit_sel incremented modulo 4 (3 wraps to 0).
- Any state->IDLE on the cycle after en=0.
REQ-009 Outputs per state SHALL be:
- IDLE and BLANK: an=4'hF and seg=8'hFF.
- SHOW: an has only bit digit_sel low, and seg=~active[digit_sel].
REQ-010 The commit cycle SHALL be the SHOW->BLANK transition with digit_sel=3; in it, all four active registers SHALL load from shadow, and the write stalls for that cycle.
REQ-011 In IDLE, active SHALL copy shadow every cycle, so a write becomes visible no later than the first SHOW after en rises.
REQ-012 Entering IDLE SHALL reset digit_sel to 0 and clear the slot counter; leaving IDLE SHALL start BLANK with digit_sel=0.
REQ-013 A write to the digit currently in SHOW SHALL NOT alter seg until after the next commit.
REQ-014 If en falls in the same cycle as a write, the write SHALL still be accepted.
REQ-015 seg, an and digit_sel SHALL be registered outputs with no combinational path from any input.
REQ-016 Latency from the en rising edge to an[0]=0 SHALL be 1+BLANK_CYC cycles.

Reset
REQ-017 While rst_n=0 at a clk edge, the block SHALL enter IDLE with shadow=0, active=0, digit_sel=0, counters=0, seg=8'hFF, an=4'hF and wr_ready=0.
REQ-018 Reset asserted mid-SHOW SHALL blank the outputs on the next edge, and pending shadow data SHALL be discarded.
REQ-019 wr_ready SHALL become 1 on the first edge after rst_n returns to 1.

Structure
REQ-020 The shared package SHALL hold the state enumeration, N_DIG=4, SEG_OFF=8'hFF and AN_OFF=4'hF.
REQ-021 The slot/blank cycle counter SHALL be a sub-module disp_tick, which takes a load value and restart and produces done.
REQ-022 The remaining logic (FSM, shadow/active banks, handshake) SHALL reside in disp_scan.

Verification (DIV=4, BLANK_CYC=1)
REQ-023 Reset release -> seg=FF, an=F, wr_ready=1 next cycle; en=1 -> an=E on cycle 2 with seg=~active[0].
REQ-024 Write digits 0..3 = 3F,06,5B,4F in IDLE, then en=1 -> seg sequence C0,F9,A4,B0, each held 4 cycles, separated by 1 blank cycle, with an E,D,B,7.
REQ-025 Write digit 1=7F while digit 1 is shown -> seg unchanged (F9) in this frame, F9->80 in the next frame.
REQ-026 Hold wr_valid=1 through the commit cycle -> wr_ready=0 for exactly 1 cycle, and the write is accepted on the following cycle.
REQ-027 Drop en mid-SHOW of digit 2 -> next cycle an=F, digit_sel=0; re-raise en -> digit 0 is lit after 2 cycles.
REQ-028 Assert rst_n=0 mid-SHOW -> an=F and seg=FF next edge, and a subsequent en=1 frame shows all-dark (active=0).

Source files
------------

// File: rtl/disp_scan_pkg.sv
// Shared definitions for the 4-digit multiplexed display scanner.
// Holds the scan FSM state encoding, the digit count, the all-off drive
// levels for the active-low segment and anode outputs, and the width of
// the slot/blank cycle counter.
package disp_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  localparam int          N_DIG   = 4;
  localparam logic [7:0]  SEG_OFF = 8'hFF;
  localparam logic [3:0]  AN_OFF  = 4'hF;

  // Wide enough for a load value of DIV-1 with DIV up to 2^20.
  localparam int          CNT_W   = 20;

endpackage

// File: rtl/disp_scan_tick.sv
// Slot/blank cycle counter for disp_scan.
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   restart  load the counter with 'load' on this edge
//   load     cycles-minus-one to count before done
//   done     high while the counter has reached zero
// After a restart with value N-1, done is high in the Nth cycle, so a
// state that restarts on entry and leaves on done lasts exactly N cycles.
module disp_tick
  import disp_scan_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart,
  input  logic [W-1:0] load,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= load;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/disp_scan.sv
// Four-digit multiplexed 7-segment display scanner.
// Writes land in a shadow bank; the visible (active) bank is refreshed from
// shadow at the end of every full frame (the commit cycle) and continuously
// while the display is idle, so a digit never changes in the middle of a frame.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   en         display enable
//   wr_valid   write request
//   wr_ready   write accept (low in the commit cycle and during reset)
//   wr_addr    target digit 0..3
//   wr_data    segment pattern, 1 = lit, bit7 = dp
//   seg        segment drive, active-low (registered)
//   an         digit anodes, active-low (registered)
//   digit_sel  index of the digit currently scanned (registered)
module disp_scan
  import disp_scan_pkg::*;
#(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic [1:0] digit_sel
);

  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);

  state_t                       state_q, state_n;
  logic [1:0]                   dsel_q, dsel_n;
  logic                         ready_q;
  logic [N_DIG-1:0][7:0]        shadow_q;
  logic [N_DIG-1:0][7:0]        active_q;
  logic [7:0]                   seg_q, seg_n;
  logic [3:0]                   an_q, an_n;

  logic                         done;
  logic                         restart;
  logic [CNT_W-1:0]             load;
  logic                         commit;
  logic                         wr_fire;

  disp_tick #(.W(CNT_W)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .load    (load),
    .done    (done)
  );

  // Last cycle of digit 3 with the display still enabled: frame boundary.
  assign commit   = en && (state_q == ST_SHOW) && done && (dsel_q == 2'd3);
  assign wr_ready = ready_q && !commit;
  assign wr_fire  = wr_valid && wr_ready;

  // State register, digit index and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dsel_q  <= 2'd0;
      ready_q <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      state_q <= state_n;
      dsel_q  <= dsel_n;
      ready_q <= 1'b1;
      seg_q   <= seg_n;
      an_q    <= an_n;
    end
  end

  // Shadow and active digit banks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_fire) begin
        shadow_q[wr_addr] <= wr_data;
      end
      // The stalled write never races the commit: it lands one cycle later.
      if (commit || (state_q == ST_IDLE)) begin
        active_q <= shadow_q;
      end
    end
  end

  // Next-state logic; dropping en overrides every other transition.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (en)   state_n = ST_BLANK;
      ST_BLANK: if (done) state_n = ST_SHOW;
      ST_SHOW:  if (done) state_n = ST_BLANK;
      default:            state_n = ST_IDLE;
    endcase
    if (!en) begin
      state_n = ST_IDLE;
    end
  end

  // Digit index and counter control follow the chosen transition.
  always_comb begin
    dsel_n = dsel_q;
    if (state_n == ST_IDLE) begin
      dsel_n = 2'd0;
    end else if ((state_q == ST_SHOW) && (state_n == ST_BLANK)) begin
      dsel_n = dsel_q + 2'd1;
    end

    // Restart on every state entry; holding restart in IDLE keeps it cleared.
    restart = (state_n != state_q) || (state_q == ST_IDLE);
    case (state_n)
      ST_SHOW:  load = SHOW_LOAD;
      ST_BLANK: load = BLANK_LOAD;
      default:  load = '0;
    endcase
  end

  // Output decode from the upcoming state so seg/an are pure registers.
  always_comb begin
    seg_n = SEG_OFF;
    an_n  = AN_OFF;
    if (state_n == ST_SHOW) begin
      an_n  = ~(4'b0001 << dsel_n);
      seg_n = ~active_q[dsel_n];
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign digit_sel = dsel_q;

endmodule
